// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int MEM_LAT_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter timing one memory access; done marks the final BUSY cycle.
module mem_arb_lat_cnt #(
    parameter int MEM_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(MEM_LAT - 1);
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and data ports onto one fixed-latency single-port memory.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise data beats fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state;
    gnt_t   gnt;
    logic   if_req_m, d_req_m, pick_d, start, cnt_done;

    // A request answered this cycle is still held by the CPU; ignore it so it is not reissued.
    assign if_req_m = if_req & ~if_valid;
    assign d_req_m  = d_req  & ~d_valid;
    assign start    = (state == IDLE) && (if_req_m || d_req_m);

`ifdef ARB_RR_EN
    gnt_t last_grant;

    assign pick_d = d_req_m & (~if_req_m | (last_grant == GNT_IF));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= GNT_IF;
        else if (start)
            last_grant <= pick_d ? GNT_D : GNT_IF;
    end
`else
    assign pick_d = d_req_m;
`endif

    mem_arb_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (start),
        .dec  (state == BUSY),
        .done (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= GNT_IF;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= BUSY;
                        mem_en <= 1'b1;
                        if (pick_d) begin
                            gnt       <= GNT_D;
                            mem_wr    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            gnt      <= GNT_IF;
                            mem_wr   <= 1'b0;
                            mem_addr <= if_addr;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_done) begin
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        mem_wr <= 1'b0;
                        if (gnt == GNT_D) begin
                            d_valid <= 1'b1;
                            if (!mem_wr)
                                d_rdata <= mem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req  & ~d_valid;

endmodule
